mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
//  Takes the same SrcA/SrcB operands the ALU sees, runs a multi-cycle shift-add
//  or shift-subtract and hands MDResult to the writeback mux.
//  The controller stalls the pipeline while Busy is high.
// PARAMETERS
//  XLEN  32  operand/result width; only 32 is supported.
// PORTS
//  clk           in   1     single clock; all state updates on rising edge
//  rst           in   1     asynchronous, active-high reset
//  Start         in   1     request; sampled only in IDLE or DONE
//  MDControl     in   3     funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                           100 DIV 101 DIVU 110 REM 111 REMU
//  SrcA          in   32    rs1 operand (multiplicand / dividend)
//  SrcB          in   32    rs2 operand (multiplier / divisor)
//  Busy          out  1     operation in progress
//  Done          out  1     one-cycle pulse; MDResult valid
//  MDResult      out  32    result; held until the next accepted Start
// BEHAVIOUR
//  Reset: state=IDLE; Busy=0, Done=0, MDResult=0; internal registers cleared.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE/DONE + Start: latch SrcA, SrcB and MDControl.
//    - Go to DONE directly on a special divide case (below).
//    - Otherwise go to MUL for funct3[2]=0, or DIV for funct3[2]=1.
//   IDLE/DONE, no Start: go to (or stay in) IDLE.
//   MUL/DIV: run 32 iterations on a 5-bit counter; after the 32nd, go to DONE.
//   DONE: Done=1 for exactly this cycle; Start in this cycle is accepted
//    (back-to-back operation).
//  Timing (the Start sample edge is cycle 0):
//    Busy=1 in cycles 1..32; Done=1 and MDResult valid in cycle 33.
//    Special divide cases: Done in cycle 1, Busy never asserted.
//  Busy = (state==MUL || state==DIV). Start while Busy is ignored.
//  Operand changes after acceptance have no effect.
//  Multiply: operands take absolute values per signedness.
//    MUL/MULH: both signed. MULHSU: SrcA signed, SrcB unsigned. MULHU: both unsigned.
//    A 64-bit unsigned product is accumulated, one multiplier bit per cycle.
//    The product is negated if the operand signs differ (signed operands only).
//    MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
//  Divide: restoring, one quotient bit per cycle on magnitudes.
//    Quotient sign = sign(A) XOR sign(B); remainder takes the sign of the dividend
//    (signed ops only).
//  Special cases, RISC-V spec values:
//    divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> latched SrcA.
//    DIV of 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM -> 0.
//  MDResult updates only on entry to DONE.
//  Reset mid-operation: abort immediately to the reset values; no Done pulse.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> MDResult 0xFFFFFFEB; Done only in cycle 33;
//   Busy high in cycles 1..32.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000;
//   MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF;
//   DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
//  DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, each with Done in cycle 1;
//   DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each with Done in cycle 1.
//  Start a DIVU, pulse Start again with other operands in cycle 5
//   -> ignored; first result returned in cycle 33.
//   Start in the Done cycle -> the next Done follows 33 cycles later.
//  Assert rst asynchronously in cycle 10 of a MUL -> Busy/Done/MDResult are 0
//   immediately; no Done afterwards; a new Start completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative RV32M multiply/divide unit for the execute stage.
//                A 64-bit shift-add multiply or a restoring shift-subtract
//                divide runs on operand magnitudes, one bit per cycle for 32
//                cycles. The sign is fixed up when the result is captured.
//                Divide by zero and signed overflow finish in one cycle with
//                the architecturally defined values.
//  Ports       : clk        - clock, all state updates on the rising edge
//                rst        - asynchronous active-high reset
//                Start      - request, sampled only in IDLE or DONE
//                MDControl  - funct3 (MUL..REMU)
//                SrcA/SrcB  - rs1 / rs2 operands
//                Busy       - high while an iteration is running
//                Done       - one-cycle pulse, MDResult valid
//                MDResult   - result, held until the next accepted Start
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [2:0]      MDControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] MDResult
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] C_LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    // Multiplicand for multiplies, divisor for divides (magnitude).
    logic [XLEN-1:0]     mcand_q, mcand_d;
    // Multiply: {partial product high, multiplier / product low}.
    // Divide:   {partial remainder, dividend / quotient}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    // Final result must be negated.
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic            w_a_signed, w_b_signed;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_neg_start;
    logic            w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    always_comb begin
        // Signed A: MUL/MULH/MULHSU, DIV/REM. Signed B: MUL/MULH, DIV/REM.
        w_a_signed = MDControl[2] ? ~MDControl[0] : (MDControl[1:0] != 2'b11);
        w_b_signed = MDControl[2] ? ~MDControl[0] : ~MDControl[1];
        w_a_neg    = w_a_signed & SrcA[XLEN-1];
        w_b_neg    = w_b_signed & SrcB[XLEN-1];
        w_a_mag    = w_a_neg ? -SrcA : SrcA;
        w_b_mag    = w_b_neg ? -SrcB : SrcB;
        // Remainder follows the dividend; everything else follows the XOR.
        w_neg_start = (MDControl[2] & MDControl[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

        w_div_zero = (SrcB == '0);
        w_div_ovf  = ~MDControl[0] & (SrcA == C_INT_MIN) & (SrcB == '1);
        w_special  = MDControl[2] & (w_div_zero | w_div_ovf);

        if (w_div_zero)
            w_special_res = MDControl[1] ? SrcA : '1;
        else
            w_special_res = MDControl[1] ? '0 : C_INT_MIN;
    end

    // ------------------------------------------------------------------
    // One iteration of multiply / divide
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_top;
    logic [XLEN+1:0]   w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_iter;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the 65-bit {carry, acc} right.
        if (acc_q[0])
            w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        else
            w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]};
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

        // Restoring: shift left one, trial-subtract the divisor from the top.
        // The partial remainder is always below the divisor, so the shifted
        // top fits in XLEN+1 bits and a kept difference fits in XLEN bits.
        w_div_top  = acc_q[2*XLEN-1:XLEN-1];
        w_div_diff = {1'b0, w_div_top} - {2'b00, mcand_q};
        w_div_ge   = ~w_div_diff[XLEN+1];
        if (w_div_ge)
            w_div_next = {w_div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            w_div_next = {acc_q[2*XLEN-2:0], 1'b0};

        w_iter = (state_q == S_DIV) ? w_div_next : w_mul_next;
    end

    // ------------------------------------------------------------------
    // Result formation from the final iteration
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_final;

    always_comb begin
        w_prod    = neg_q ? -w_iter : w_iter;
        w_mul_res = (op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        w_div_raw = op_q[1] ? w_iter[2*XLEN-1:XLEN] : w_iter[XLEN-1:0];
        w_div_res = neg_q ? -w_div_raw : w_div_raw;
        w_final   = op_q[2] ? w_div_res : w_mul_res;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    op_d    = MDControl;
                    cnt_d   = '0;
                    mcand_d = w_b_mag;
                    acc_d   = {{XLEN{1'b0}}, w_a_mag};
                    neg_d   = w_neg_start;
                    if (w_special) begin
                        state_d  = S_DONE;
                        result_d = w_special_res;
                    end else begin
                        state_d = MDControl[2] ? S_DIV : S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                acc_d = w_iter;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAST_ITER) begin
                    state_d  = S_DONE;
                    result_d = w_final;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign MDResult = result_q;

endmodule
`default_nettype wire
